// File: rtl/memsys_pkg.sv
// Shared memory-system definitions: SRAM sequencer states, requester ids and
// SRAM/block geometry used to size the arbiter.
package memsys_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_W_SETUP  = 3'd1,
    S_W_STROBE = 3'd2,
    S_R_ADDR   = 3'd3,
    S_R_CAP    = 3'd4,
    S_TURN     = 3'd5
  } state_e;

  localparam int PORT_RF     = 0;
  localparam int PORT_DBG    = 1;
  localparam int SRAM_DEPTH  = 2048;
  localparam int BLOCK_WORDS = 32;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The pointer only moves when both ports
// contend, so a lone requester never steals the other port's next turn.
module rr_arbiter2
  import memsys_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant,
  output logic       ptr_q
);

  always_comb begin
    grant = req[1];
    if (req == 2'b11) grant = ptr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= 1'(PORT_RF);
    end else if (advance && (req == 2'b11)) begin
      ptr_q <= ~ptr_q;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares the 2048x32 asynchronous SRAM between the register-file engine and the
// debug reader, sequencing write strobes, output enable and bus turnaround.
module sram_arbiter
  import memsys_pkg::*;
#(
  parameter int ADDR_W = $clog2(SRAM_DEPTH),
  parameter int DATA_W = 32,
  parameter int LEN_W  = $clog2(BLOCK_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [LEN_W-1:0]  len0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              ack0,
  output logic              done0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [LEN_W-1:0]  len1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              ack1,
  output logic              done1,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] sram_adrx,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_wdata_en,
  output logic              sram_read,
  output logic              sram_not_out_en,
  input  logic [DATA_W-1:0] sram_rdata
);

  state_e            state_q;
  logic              owner_q;
  logic [ADDR_W-1:0] baseAddr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_q;
  logic [LEN_W-1:0]  beat_d;
  logic [ADDR_W-1:0] adrx_d;

  logic              grantIdx;
  logic              unusedRrPtr;
  logic              startXfer;
  logic              lastBeat;
  logic              ownerIsDbg;
  logic              selWe;
  logic [ADDR_W-1:0] selAddr;
  logic [LEN_W-1:0]  selLen;
  logic [DATA_W-1:0] selWdata;
  logic [DATA_W-1:0] ownerWdata;

  assign startXfer = (state_q == S_IDLE) && (req0 || req1);

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1, req0}),
    .advance (startXfer),
    .grant   (grantIdx),
    .ptr_q   (unusedRrPtr)
  );

  // Address wraps naturally at 2^ADDR_W because adrx_d is ADDR_W bits wide.
  always_comb begin
    selWe      = grantIdx ? we1    : we0;
    selAddr    = grantIdx ? addr1  : addr0;
    selLen     = grantIdx ? len1   : len0;
    selWdata   = grantIdx ? wdata1 : wdata0;
    ownerWdata = owner_q  ? wdata1 : wdata0;
    ownerIsDbg = (owner_q == 1'(PORT_DBG));
    beat_d     = beat_q + 1'b1;
    adrx_d     = baseAddr_q + ADDR_W'(beat_d);
    lastBeat   = (beat_q == len_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      owner_q         <= 1'b0;
      baseAddr_q      <= '0;
      len_q           <= '0;
      beat_q          <= '0;
      gnt0            <= 1'b0;
      gnt1            <= 1'b0;
      ack0            <= 1'b0;
      ack1            <= 1'b0;
      done0           <= 1'b0;
      done1           <= 1'b0;
      rvalid          <= '0;
      rdata           <= '0;
      sram_adrx       <= '0;
      sram_wdata      <= '0;
      sram_wdata_en   <= 1'b0;
      sram_read       <= 1'b1;
      sram_not_out_en <= 1'b1;
    end else begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      rvalid <= '0;
      case (state_q)
        S_IDLE: begin
          if (startXfer) begin
            owner_q    <= grantIdx;
            baseAddr_q <= selAddr;
            len_q      <= selLen;
            beat_q     <= '0;
            gnt0       <= ~grantIdx;
            gnt1       <= grantIdx;
            sram_adrx  <= selAddr;
            if (selWe) begin
              state_q       <= S_W_SETUP;
              sram_wdata    <= selWdata;
              sram_wdata_en <= 1'b1;
            end else begin
              state_q         <= S_R_ADDR;
              sram_not_out_en <= 1'b0;
            end
          end
        end
        S_W_SETUP: begin
          sram_wdata <= ownerWdata;
          sram_read  <= 1'b0;
          ack0       <= ~ownerIsDbg;
          ack1       <= ownerIsDbg;
          state_q    <= S_W_STROBE;
        end
        S_W_STROBE: begin
          sram_read <= 1'b1;
          if (lastBeat) begin
            sram_wdata_en <= 1'b0;
            done0         <= ~ownerIsDbg;
            done1         <= ownerIsDbg;
            state_q       <= S_TURN;
          end else begin
            beat_q    <= beat_d;
            sram_adrx <= adrx_d;
            state_q   <= S_W_SETUP;
          end
        end
        S_R_ADDR: begin
          state_q <= S_R_CAP;
        end
        S_R_CAP: begin
          rdata  <= sram_rdata;
          rvalid <= ownerIsDbg ? 2'b10 : 2'b01;
          if (lastBeat) begin
            sram_not_out_en <= 1'b1;
            done0           <= ~ownerIsDbg;
            done1           <= ownerIsDbg;
            state_q         <= S_TURN;
          end else begin
            beat_q    <= beat_d;
            sram_adrx <= adrx_d;
            state_q   <= S_R_ADDR;
          end
        end
        S_TURN: begin
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a behavioural SRAM, per-feature scenario
// tasks with hand-computed expectations and a bus-contention monitor.
module tb_sram_arbiter;
  import memsys_pkg::*;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    req = '0;
  logic [1:0]    we  = '0;
  logic [AW-1:0] addrV  [2];
  logic [LW-1:0] lenV   [2];
  logic [DW-1:0] wdataV [2];
  wire  [1:0]    gnt;
  wire  [1:0]    ack;
  wire  [1:0]    done;
  wire  [1:0]    rvalid;
  wire  [DW-1:0] rdata;
  wire  [AW-1:0] sram_adrx;
  wire  [DW-1:0] sram_wdata;
  wire           sram_wdata_en;
  wire           sram_read;
  wire           sram_not_out_en;
  wire  [DW-1:0] sram_rdata;

  logic [DW-1:0] mem [2048];
  logic          preEn = 1'b0;
  logic [AW-1:0] preAdr = '0;
  logic [DW-1:0] preDat = '0;

  logic [DW-1:0] wbuf [32];
  logic [DW-1:0] rdQ0 [$];
  logic [DW-1:0] rdQ1 [$];
  logic [AW-1:0] strobeAdr [$];
  logic [DW-1:0] strobeDat [$];
  logic [DW-1:0] shadow [2048];
  bit            known  [2048];
  int            bothOn = 0;
  int            noTurn = 0;
  bit            readPend = 1'b0;

  int total = 0;
  int bad   = 0;

  sram_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .req0            (req[0]),
    .we0             (we[0]),
    .addr0           (addrV[0]),
    .len0            (lenV[0]),
    .wdata0          (wdataV[0]),
    .gnt0            (gnt[0]),
    .ack0            (ack[0]),
    .done0           (done[0]),
    .req1            (req[1]),
    .we1             (we[1]),
    .addr1           (addrV[1]),
    .len1            (lenV[1]),
    .wdata1          (wdataV[1]),
    .gnt1            (gnt[1]),
    .ack1            (ack[1]),
    .done1           (done[1]),
    .rvalid          (rvalid),
    .rdata           (rdata),
    .sram_adrx       (sram_adrx),
    .sram_wdata      (sram_wdata),
    .sram_wdata_en   (sram_wdata_en),
    .sram_read       (sram_read),
    .sram_not_out_en (sram_not_out_en),
    .sram_rdata      (sram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: write latched while the strobe is low, read is combinational.
  assign sram_rdata = sram_not_out_en ? '0 : mem[sram_adrx];

  always @(posedge clk) begin
    if (preEn) mem[preAdr] <= preDat;
    else if (!sram_read && sram_wdata_en) mem[sram_adrx] <= sram_wdata;
  end

  // Mid-cycle monitor: read beats, strobe log and tristate/turnaround rules.
  always @(negedge clk) begin
    if (rvalid[0]) rdQ0.push_back(rdata);
    if (rvalid[1]) rdQ1.push_back(rdata);
    if (!sram_read) begin
      strobeAdr.push_back(sram_adrx);
      strobeDat.push_back(sram_wdata);
    end
    if (sram_wdata_en && !sram_not_out_en) bothOn++;
    if (sram_wdata_en && readPend) noTurn++;
    if (!sram_not_out_en) readPend = 1'b1;
    if (done != 2'b00) readPend = 1'b0;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    preAdr = a;
    preDat = d;
    preEn  = 1'b1;
    tick();
    preEn  = 1'b0;
  endtask

  task automatic runTransfer(input int p, input logic w, input logic [AW-1:0] a,
                             input logic [LW-1:0] l, output bit ok);
    int beat = 0;
    bit pending = 1'b0;
    ok = 1'b0;
    we[p] = w;
    addrV[p] = a;
    lenV[p] = l;
    wdataV[p] = wbuf[0];
    req[p] = 1'b1;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (gnt[p]) req[p] = 1'b0;
      if (pending) begin
        wdataV[p] = wbuf[beat];
        pending = 1'b0;
      end
      if (ack[p]) begin
        beat++;
        if (beat < 32) pending = 1'b1;
      end
      if (done[p]) begin
        ok = 1'b1;
        break;
      end
    end
    req[p] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++; if (gnt !== 2'b00) begin bad++; $display("[TB] FAIL reset_gnt: got %b want 00", gnt); end
    total++; if ({ack, done, rvalid} !== 6'b0) begin bad++; $display("[TB] FAIL reset_pulses: got %b want 000000", {ack, done, rvalid}); end
    total++; if (rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_rdata: got %h want 0", rdata); end
    total++; if (sram_adrx !== 11'h0 || sram_wdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_bus: adrx %h wdata %h want 0/0", sram_adrx, sram_wdata); end
    total++; if ({sram_wdata_en, sram_read, sram_not_out_en} !== 3'b011) begin bad++; $display("[TB] FAIL reset_ctrl: got %b want 011", {sram_wdata_en, sram_read, sram_not_out_en}); end
    rst = 1'b1;
    tick();
    total++; if (gnt !== 2'b00 || dut.state_q !== S_IDLE) begin bad++; $display("[TB] FAIL reset_release_idle: gnt %b state %0d want 00/IDLE", gnt, dut.state_q); end
  endtask

  task automatic test_single_write();
    int stBase = strobeAdr.size();
    we[0] = 1'b1; addrV[0] = 11'h005; lenV[0] = 5'd0; wdataV[0] = 32'h7F; req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    total++; if (gnt !== 2'b01 || sram_adrx !== 11'h005) begin bad++; $display("[TB] FAIL wr_setup_gnt_adrx: gnt %b adrx %h want 01/005", gnt, sram_adrx); end
    total++; if ({sram_wdata_en, sram_read, sram_not_out_en} !== 3'b111) begin bad++; $display("[TB] FAIL wr_setup_ctrl: got %b want 111", {sram_wdata_en, sram_read, sram_not_out_en}); end
    tick();
    total++; if (sram_read !== 1'b0 || ack !== 2'b01) begin bad++; $display("[TB] FAIL wr_strobe: read %b ack %b want 0/01", sram_read, ack); end
    total++; if (sram_wdata !== 32'h7F || sram_adrx !== 11'h005) begin bad++; $display("[TB] FAIL wr_strobe_bus: wdata %h adrx %h want 7f/005", sram_wdata, sram_adrx); end
    tick();
    total++; if (done !== 2'b01 || ack !== 2'b00 || gnt !== 2'b01) begin bad++; $display("[TB] FAIL wr_turn: done %b ack %b gnt %b want 01/00/01", done, ack, gnt); end
    total++; if (sram_read !== 1'b1 || sram_wdata_en !== 1'b0) begin bad++; $display("[TB] FAIL wr_turn_ctrl: read %b wen %b want 1/0", sram_read, sram_wdata_en); end
    tick();
    total++; if (gnt !== 2'b00 || done !== 2'b00) begin bad++; $display("[TB] FAIL wr_idle: gnt %b done %b want 00/00", gnt, done); end
    total++; if (strobeAdr.size() - stBase !== 1) begin bad++; $display("[TB] FAIL wr_strobe_count: got %0d want 1", strobeAdr.size() - stBase); end
    else if (strobeAdr[stBase] !== 11'h005 || strobeDat[stBase] !== 32'h7F) begin bad++; $display("[TB] FAIL wr_strobe_log: got %h/%h want 005/7f", strobeAdr[stBase], strobeDat[stBase]); end
  endtask

  task automatic test_read_burst();
    int nValid = 0;
    int doneAt = -1;
    int stray = 0;
    bit weSeen = 1'b0;
    logic [DW-1:0] got [4];
    for (int i = 0; i < 4; i++) preload(11'h080 + 11'(i), 32'(i + 1));
    we[1] = 1'b0; addrV[1] = 11'h080; lenV[1] = 5'd3; req[1] = 1'b1;
    tick();
    req[1] = 1'b0;
    total++; if (gnt !== 2'b10 || sram_not_out_en !== 1'b0 || sram_adrx !== 11'h080) begin bad++; $display("[TB] FAIL rd_first_addr: gnt %b oe_n %b adrx %h want 10/0/080", gnt, sram_not_out_en, sram_adrx); end
    for (int k = 0; k < 20; k++) begin
      if (sram_wdata_en) weSeen = 1'b1;
      if (rvalid[0]) stray++;
      if (rvalid[1]) begin
        if (nValid < 4) got[nValid] = rdata;
        nValid++;
      end
      if (done[1]) begin
        doneAt = k;
        break;
      end
      tick();
    end
    tick();
    total++; if (doneAt !== 8) begin bad++; $display("[TB] FAIL rd_done_cycle: got %0d want 8", doneAt); end
    total++; if (nValid !== 4 || stray !== 0) begin bad++; $display("[TB] FAIL rd_rvalid_count: port1 %0d port0 %0d want 4/0", nValid, stray); end
    for (int i = 0; i < 4; i++) begin
      total++; if (nValid > i && got[i] !== 32'(i + 1)) begin bad++; $display("[TB] FAIL rd_data%0d: got %h want %h", i, got[i], 32'(i + 1)); end
    end
    total++; if (weSeen !== 1'b0) begin bad++; $display("[TB] FAIL rd_wdata_en: got 1 want 0"); end
  endtask

  task automatic test_simultaneous();
    int gnt1At = -1;
    bit found = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    we = 2'b00;
    addrV[0] = 11'h080; lenV[0] = 5'd0;
    addrV[1] = 11'h081; lenV[1] = 5'd0;
    req = 2'b11;
    tick();
    total++; if (gnt !== 2'b01) begin bad++; $display("[TB] FAIL rr_first: gnt %b want 01", gnt); end
    req[0] = 1'b0;
    for (int k = 1; k < 20; k++) begin
      tick();
      if (gnt[1]) begin
        gnt1At = k;
        break;
      end
    end
    total++; if (gnt1At !== 4 || gnt[0] !== 1'b0) begin bad++; $display("[TB] FAIL rr_second_port1: cycle %0d gnt0 %b want 4/0", gnt1At, gnt[0]); end
    req[1] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (gnt == 2'b00) break;
    end
    req = 2'b11;
    tick();
    total++; if (gnt !== 2'b10) begin bad++; $display("[TB] FAIL rr_pair2_first: gnt %b want 10", gnt); end
    req[1] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (gnt[0]) begin
        found = 1'b1;
        break;
      end
    end
    req[0] = 1'b0;
    total++; if (found !== 1'b1) begin bad++; $display("[TB] FAIL rr_pair2_second: gnt0 seen %b want 1", found); end
    for (int k = 0; k < 10; k++) begin
      tick();
      if (gnt == 2'b00) break;
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int stBase = strobeAdr.size();
    int rdBase;
    wbuf[0] = 32'hAAAA_0001;
    wbuf[1] = 32'hBBBB_0002;
    runTransfer(0, 1'b1, 11'h7FF, 5'd1, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL wrap_wr_timeout: done %b want 1", ok); end
    total++; if (strobeAdr.size() - stBase !== 2) begin bad++; $display("[TB] FAIL wrap_strobe_count: got %0d want 2", strobeAdr.size() - stBase); end
    else begin
      total++; if (strobeAdr[stBase] !== 11'h7FF || strobeDat[stBase] !== 32'hAAAA_0001) begin bad++; $display("[TB] FAIL wrap_beat0: got %h/%h want 7ff/aaaa0001", strobeAdr[stBase], strobeDat[stBase]); end
      total++; if (strobeAdr[stBase + 1] !== 11'h000 || strobeDat[stBase + 1] !== 32'hBBBB_0002) begin bad++; $display("[TB] FAIL wrap_beat1: got %h/%h want 000/bbbb0002", strobeAdr[stBase + 1], strobeDat[stBase + 1]); end
    end
    rdBase = rdQ1.size();
    runTransfer(1, 1'b0, 11'h7FF, 5'd1, ok);
    total++; if (ok !== 1'b1 || rdQ1.size() - rdBase !== 2) begin bad++; $display("[TB] FAIL wrap_rd_count: done %b beats %0d want 1/2", ok, rdQ1.size() - rdBase); end
    else if (rdQ1[rdBase] !== 32'hAAAA_0001 || rdQ1[rdBase + 1] !== 32'hBBBB_0002) begin bad++; $display("[TB] FAIL wrap_rd_data: got %h/%h want aaaa0001/bbbb0002", rdQ1[rdBase], rdQ1[rdBase + 1]); end
  endtask

  task automatic test_reset_midburst();
    int acks = 0;
    int beat = 0;
    bit pending = 1'b0;
    bit hit = 1'b0;
    bit doneSeen = 1'b0;
    bit ok;
    int rdBase;
    for (int i = 0; i < 8; i++) wbuf[i] = 32'h1000 + 32'(i);
    we[0] = 1'b1; addrV[0] = 11'h100; lenV[0] = 5'd7; wdataV[0] = wbuf[0]; req[0] = 1'b1;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (gnt[0]) req[0] = 1'b0;
      if (pending) begin
        wdataV[0] = wbuf[beat];
        pending = 1'b0;
      end
      if (ack[0]) begin
        acks++;
        beat++;
        pending = 1'b1;
      end
      if (acks == 3) begin
        hit = 1'b1;
        break;
      end
    end
    req[0] = 1'b0;
    total++; if (hit !== 1'b1 || sram_read !== 1'b0) begin bad++; $display("[TB] FAIL abort_reach_beat2: reached %b strobe %b want 1/0", hit, sram_read); end
    #2 rst = 1'b0;
    #1;
    total++; if (sram_read !== 1'b1 || sram_wdata_en !== 1'b0) begin bad++; $display("[TB] FAIL abort_strobe: read %b wen %b want 1/0", sram_read, sram_wdata_en); end
    total++; if (gnt !== 2'b00 || ack !== 2'b00 || dut.state_q !== S_IDLE) begin bad++; $display("[TB] FAIL abort_state: gnt %b ack %b state %0d want 00/00/IDLE", gnt, ack, dut.state_q); end
    #3 rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done[0]) doneSeen = 1'b1;
    end
    total++; if (doneSeen !== 1'b0) begin bad++; $display("[TB] FAIL abort_no_done: done0 seen %b want 0", doneSeen); end
    rdBase = rdQ0.size();
    runTransfer(0, 1'b0, 11'h080, 5'd0, ok);
    total++; if (ok !== 1'b1 || rdQ0.size() - rdBase !== 1) begin bad++; $display("[TB] FAIL abort_next_req: done %b beats %0d want 1/1", ok, rdQ0.size() - rdBase); end
    else if (rdQ0[rdBase] !== 32'h1) begin bad++; $display("[TB] FAIL abort_next_data: got %h want 1", rdQ0[rdBase]); end
  endtask

  task automatic test_random();
    bit ok;
    int p;
    logic w;
    logic [AW-1:0] a;
    logic [AW-1:0] adr;
    logic [LW-1:0] l;
    int rdBase;
    int nGot;
    logic [DW-1:0] gotV;
    for (int t = 0; t < 200; t++) begin
      p = int'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = 11'h400 + 11'($urandom_range(0, 63));
      l = 5'($urandom_range(0, 7));
      if (w) begin
        for (int i = 0; i < 32; i++) wbuf[i] = $urandom;
        runTransfer(p, 1'b1, a, l, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL rand_wr_timeout: txn %0d done %b want 1", t, ok); end
        for (int i = 0; i <= int'(l); i++) begin
          adr = a + 11'(i);
          shadow[adr] = wbuf[i];
          known[adr] = 1'b1;
        end
      end else begin
        rdBase = (p == 0) ? rdQ0.size() : rdQ1.size();
        runTransfer(p, 1'b0, a, l, ok);
        nGot = ((p == 0) ? rdQ0.size() : rdQ1.size()) - rdBase;
        total++; if (ok !== 1'b1 || nGot !== int'(l) + 1) begin bad++; $display("[TB] FAIL rand_rd_count: txn %0d done %b beats %0d want 1/%0d", t, ok, nGot, int'(l) + 1); end
        else begin
          for (int i = 0; i <= int'(l); i++) begin
            adr = a + 11'(i);
            gotV = (p == 0) ? rdQ0[rdBase + i] : rdQ1[rdBase + i];
            if (known[adr]) begin
              total++; if (gotV !== shadow[adr]) begin bad++; $display("[TB] FAIL rand_rd_data: txn %0d adr %h got %h want %h", t, adr, gotV, shadow[adr]); end
            end
          end
        end
      end
    end
    total++; if (bothOn !== 0) begin bad++; $display("[TB] FAIL tristate_overlap: got %0d cycles want 0", bothOn); end
    total++; if (noTurn !== 0) begin bad++; $display("[TB] FAIL read_write_turnaround: got %0d cycles want 0", noTurn); end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      addrV[i] = '0;
      lenV[i] = '0;
      wdataV[i] = '0;
    end
    for (int i = 0; i < 32; i++) wbuf[i] = '0;
    for (int i = 0; i < 2048; i++) begin
      shadow[i] = '0;
      known[i] = 1'b0;
    end
    test_reset();
    test_single_write();
    test_read_burst();
    test_simultaneous();
    test_wrap();
    test_reset_midburst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Sequences the shared 2048x32 SRAM and shares it between two requesters.
  - Port 0: the register-file fill/writeback engine.
  - Port 1: the debug/display reader.
- Burst transfers of 1-32 words, which matches the 32-word block granularity of the memory system.
- Round-robin arbitration between the two ports.
- Generates the two-phase SRAM write strobe (setup, then strobe) and the output-enable sequencing the SRAM needs.
- Inserts a bus-turnaround cycle so the tristate data bus is never double-driven.

Parameters:
ADDR_W, 11, SRAM word-address width
DATA_W, 32, SRAM data width
LEN_W, 5, burst length field width (length = len+1 beats, 1..32)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (0 = reset)
req0  in  1  port 0 request; sampled only in IDLE
we0  in  1  port 0 direction: 1 = write, 0 = read
addr0  in  ADDR_W  port 0 start address
len0  in  LEN_W  port 0 beats minus 1
wdata0  in  DATA_W  port 0 write data for the current beat
gnt0  out  1  port 0 owns the SRAM
ack0  out  1  port 0 write beat consumed; requester presents the next word the following cycle
done0  out  1  port 0 transaction complete (1-cycle pulse)
req1, we1, addr1, len1, wdata1, gnt1, ack1, done1  same as port 0, for port 1
rvalid  out  2  one-hot read-data valid, per port
rdata  out  DATA_W  read data, registered
sram_adrx  out  ADDR_W  SRAM address
sram_wdata  out  DATA_W  data toward the tristate driver
sram_wdata_en  out  1  enable for the tristate data driver
sram_read  out  1  1 = no write; 0 = write strobe
sram_not_out_en  out  1  SRAM output enable, active-low
sram_rdata  in  DATA_W  SRAM data bus as read

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state=IDLE, rr pointer=port 0 preferred;
  - gnt*/ack*/done*/rvalid=0, rdata=0, sram_adrx=0, sram_wdata=0;
  - sram_wdata_en=0, sram_read=1, sram_not_out_en=1.
- Reset mid-burst aborts the transfer immediately. The SRAM strobe returns high asynchronously and no done is issued.
- All outputs are registered.
- States: IDLE, W_SETUP, W_STROBE, R_ADDR, R_CAP, TURN.
- IDLE:
  - If exactly one req is high, grant that port.
  - If both are high, grant the port the rr pointer favours. The pointer then flips to the other port.
  - The granted port's we, addr and len are latched, and beat count is set to 0.
  - Next state is W_SETUP if we=1, else R_ADDR.
  - gnt goes high on the first transfer cycle and stays high through TURN inclusive.
- W_SETUP:
  - sram_adrx = base+beat, sram_wdata = wdata of the owner, sram_wdata_en=1, sram_read=1.
  - Next state: W_STROBE.
- W_STROBE:
  - sram_read=0; address and data are held.
  - ack of the owner pulses.
  - If beat==len, go to TURN; else beat++ and go to W_SETUP.
- R_ADDR:
  - sram_adrx = base+beat, sram_not_out_en=0, sram_wdata_en=0.
  - Next state: R_CAP.
- R_CAP:
  - sram_not_out_en=0; rdata is loaded from sram_rdata.
  - rvalid[owner] is 1 on the following cycle, aligned with rdata.
  - If beat==len, go to TURN; else beat++ and go to R_ADDR.
- TURN:
  - sram_not_out_en=1, sram_wdata_en=0, sram_read=1.
  - done of the owner pulses; gnt drops on the next cycle.
  - Next state: IDLE.
- sram_wdata_en and sram_not_out_en=0 are never both asserted in any cycle.
- Timing:
  - N-beat transfer occupies 2N+1 cycles.
  - Request-to-first-SRAM-cycle latency is 1 cycle.
  - A new grant is possible 1 cycle after TURN, because IDLE lasts ≥1 cycle.
- Address arithmetic is modulo 2^ADDR_W: base 2047 with len 1 accesses 2047 then 0.
- Dropping req during a transfer is ignored; the burst completes.
- If req is still high in IDLE after done, a new transaction starts; the rr pointer still applies.
- Inputs we/addr/len are ignored while not in IDLE.
- wdata is sampled in W_SETUP of each beat.

Decomposition:
- Shared package memsys_pkg:
  - state encoding localparams;
  - PORT_RF=0, PORT_DBG=1;
  - SRAM_DEPTH=2048;
  - BLOCK_WORDS=32.
- One sub-module, rr_arbiter2. Inputs: clk, rst, req[1:0], advance. Outputs: grant index and the pointer register. It is used in IDLE only.

Test Plan:
- Single write, port 0: addr=0x005, len=0, wdata=0x7F.
  - Required: W_SETUP then W_STROBE, with sram_read=0 for exactly 1 cycle at adrx=5 and sram_wdata=0x7F.
  - Required: ack0 pulses once, done0 appears 3 cycles after gnt0.
- Read burst, port 1: addr=0x080, len=3, SRAM model preloaded 0x80-0x83 = 1,2,3,4.
  - Required: rvalid[1] fires 4 times with rdata 1,2,3,4.
  - Required: done1 appears 9 cycles after the first R_ADDR, and sram_wdata_en=0 throughout.
- Simultaneous req0 and req1 immediately after reset:
  - Required: port 0 is served first, then port 1.
  - Required: a second simultaneous request pair is served port 1 first.
- Wrap-around write: addr=0x7FF, len=1, data A,B.
  - Required: writes go to 0x7FF then 0x000.
- Reset pulse (rst=0) during beat 2 of an 8-beat write.
  - Required: sram_read=1, gnt0=0, state=IDLE, with no done0.
  - Required: the next request is served normally.
- Tristate checker over a random mix of 200 transactions.
  - Required: sram_wdata_en and !sram_not_out_en are never both 1.
  - Required: there is always a TURN cycle between a read and a following write.
